// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the CPU fetch port and the CPU
//   data port. Each access runs as IDLE -> ACCESS -> (WAIT x RD_LAT) -> DONE.
//   Data wins contended grants, except that fetch is forced through after
//   FETCH_MAX_WAIT consecutive contended data grants.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   if_req/if_addr        fetch request and address
//   if_ack/if_rdata       fetch completion pulse and last fetched word
//   d_req/d_we/d_addr/d_wdata   data request, store flag, address, store data
//   d_ack/d_rdata         data completion pulse and last loaded word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
//   stall                 pipeline stall (pending request not yet acked)
//   busy                  FSM is not in IDLE
module mem_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int RD_LAT         = 1,
  parameter int FETCH_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // owner encoding: 0 = fetch port, 1 = data port
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [2:0]        wait_q, wait_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_fetch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      wait_q     <= '0;
      owner_q    <= OWN_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      wait_q     <= wait_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Fetch wins when alone, or when contended data grants have hit the limit.
    grant_fetch = if_req & (~d_req | (starve_q == 4'(FETCH_MAX_WAIT)));

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d = ST_ACCESS;
          if (grant_fetch) begin
            owner_d  = OWN_FETCH;
            we_d     = 1'b0;
            addr_d   = if_addr;
            starve_d = '0;
          end else begin
            owner_d = OWN_DATA;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            // Only a data grant that actually made fetch wait counts.
            if (if_req && (starve_q != 4'hF)) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          wait_d  = 3'(RD_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = ST_DONE;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ack    = (state_q == ST_DONE) & (owner_q == OWN_FETCH);
  assign d_ack     = (state_q == ST_DONE) & (owner_q == OWN_DATA);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign busy      = (state_q != ST_IDLE);
  assign stall     = reset & ((if_req & ~if_ack) | (d_req & ~d_ack));

endmodule
